spi_csr_bridge: RTL and testbench

//  SPI slave (mode 0, MSB first) front end that masters the CSR register-map port (addr/wdata/wen/ren/rdata).

---
 rtl/spi_csr_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_csr_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_csr_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_csr_pkg.sv
// Shared types and constants for the SPI-to-CSR bridge.
package spi_csr_pkg;

  localparam int BYTE_BITS  = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int BIT_CNT_W  = $clog2(BYTE_BITS);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ISSUE_RD,
    DATA,
    ISSUE_WR,
    DONE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad signal, followed by a
// one-cycle rise/fall pulse detector in the clk_i domain.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronise the pad and keep one delayed copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value;
      // blocking assignments would collapse the chain into a single flop.
      meta <= async_i;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_o = sync & ~prev;
  assign fall_o = ~sync & prev;

endmodule

// File: rtl/spi_csr_bridge.sv
// SPI mode-0 slave that decodes {rw, addr} + data frames and drives held
// read/write strobes on the CSR register-map port.
// Optional feature macro: SPI_BURST_EN (auto-incrementing multi-byte frames).
module spi_csr_bridge
  import spi_csr_pkg::*;
#(
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int STROBE_CYCLES = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sck_i,
  input  logic                  csn_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  busy_o,
  output logic                  frame_err_o
);

  localparam int                   CNT_W       = $clog2(STROBE_CYCLES);
  localparam logic [CNT_W-1:0]     STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST    = BIT_CNT_W'(BYTE_BITS - 1);

  logic sck_rise;
  logic sck_fall;
  logic csn_rise;
  logic csn_fall;
  logic mosi_meta;
  logic mosi_s;
  logic selected;

  state_t                state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-2:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic                  is_read;
  logic [CNT_W-1:0]      strobe_cnt;
`ifdef SPI_BURST_EN
  logic                  byte_done;
`endif

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (sck_i),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_csn_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (csn_i),
    .rise_o  (csn_rise),
    .fall_o  (csn_fall)
  );

  // Two-flop synchroniser for MOSI; same depth as sck so data lines up with the edge pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi_i;
      mosi_s    <= mosi_meta;
    end
  end

  // miso_oe_o doubles as the registered "chip selected" flag; this is its next value.
  assign selected = csn_fall | (miso_oe_o & ~csn_rise);
  assign rx_next  = {rx_sr, mosi_s};

  // Frame FSM with all CSR-side outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      is_read      <= 1'b0;
      strobe_cnt   <= '0;
      miso_o       <= 1'b0;
      miso_oe_o    <= 1'b0;
      addr_o       <= '0;
      write_data_o <= '0;
      write_en_o   <= 1'b0;
      read_en_o    <= 1'b0;
      busy_o       <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef SPI_BURST_EN
      byte_done    <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      miso_oe_o   <= selected;

      // Shift out on every falling sck while selected; tx_sr is zero unless loaded by a read.
      if (sck_fall && selected) begin
        miso_o <= tx_sr[DATA_WIDTH-1];
        tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      end

      case (state)
        IDLE: begin
          if (csn_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
            tx_sr   <= '0;
            miso_o  <= 1'b0;
`ifdef SPI_BURST_EN
            byte_done <= 1'b0;
`endif
          end
        end

        CMD: begin
          if (!selected) begin
            frame_err_o <= 1'b1;
            state       <= IDLE;
          end else if (sck_rise) begin
            rx_sr   <= rx_next[DATA_WIDTH-2:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              addr_o  <= rx_next[ADDR_WIDTH-1:0];
              is_read <= rx_next[CMD_RW_BIT];
              if (rx_next[CMD_RW_BIT]) begin
                read_en_o  <= 1'b1;
                busy_o     <= 1'b1;
                strobe_cnt <= '0;
                state      <= ISSUE_RD;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        ISSUE_RD: begin
          strobe_cnt <= strobe_cnt + 1'b1;
          if (strobe_cnt == STROBE_LAST) begin
            read_en_o <= 1'b0;
            busy_o    <= 1'b0;
            tx_sr     <= read_data_i;
            state     <= selected ? DATA : IDLE;
          end
        end

        DATA: begin
          if (!selected) begin
`ifdef SPI_BURST_EN
            // Deselecting on a byte boundary after at least one data byte ends a burst cleanly.
            frame_err_o <= !(byte_done && bit_cnt == '0);
`else
            frame_err_o <= 1'b1;
`endif
            state <= IDLE;
          end else if (sck_rise) begin
            rx_sr   <= rx_next[DATA_WIDTH-2:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef SPI_BURST_EN
              byte_done <= 1'b1;
`endif
              if (is_read) begin
`ifdef SPI_BURST_EN
                addr_o     <= addr_o + ADDR_WIDTH'(1);
                read_en_o  <= 1'b1;
                busy_o     <= 1'b1;
                strobe_cnt <= '0;
                state      <= ISSUE_RD;
`else
                state <= DONE;
`endif
              end else begin
                write_data_o <= rx_next;
                write_en_o   <= 1'b1;
                busy_o       <= 1'b1;
                strobe_cnt   <= '0;
                state        <= ISSUE_WR;
              end
            end
          end
        end

        ISSUE_WR: begin
          strobe_cnt <= strobe_cnt + 1'b1;
          if (strobe_cnt == STROBE_LAST) begin
            write_en_o <= 1'b0;
            busy_o     <= 1'b0;
            if (!selected) begin
              state <= IDLE;
            end else begin
`ifdef SPI_BURST_EN
              addr_o <= addr_o + ADDR_WIDTH'(1);
              state  <= DATA;
`else
              state <= DONE;
`endif
            end
          end
        end

        DONE: begin
          if (!selected) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_csr_bridge.sv
// Scoreboard bench for spi_csr_bridge: a bit-banged SPI host drives frames,
// expected CSR strobes / error pulses / MISO bytes are queued at issue time
// and popped by independent monitors when the DUT produces them.
module tb_spi_csr_bridge;

  localparam int HALF   = 80;  // sck half period: f_clk = 16 * f_sck
  localparam int STROBE = 3;

  typedef enum int {K_WR, K_RD, K_ERR} kind_e;
  typedef struct {
    kind_e      kind;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       sck_i;
  logic       csn_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;
  logic [6:0] addr_o;
  logic [7:0] write_data_o;
  logic       write_en_o;
  logic       read_en_o;
  logic [7:0] read_data_i;
  logic       busy_o;
  logic       frame_err_o;

  exp_t       exp_q[$];
  logic [7:0] exp_miso[$];
  logic [7:0] obs_miso[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] map_mem [64];

  always #5 clk = ~clk;

  spi_csr_bridge dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sck_i        (sck_i),
    .csn_i        (csn_i),
    .mosi_i       (mosi_i),
    .miso_o       (miso_o),
    .miso_oe_o    (miso_oe_o),
    .addr_o       (addr_o),
    .write_data_o (write_data_o),
    .write_en_o   (write_en_o),
    .read_en_o    (read_en_o),
    .read_data_i  (read_data_i),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o)
  );

  // Register map model: 64 registers at 0x00-0x3F, everything above reads 0xFF.
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) map_mem[i] <= 8'h00;
    end else if (write_en_o && !addr_o[6]) begin
      map_mem[addr_o[5:0]] <= write_data_o;
    end
  end
  assign read_data_i = addr_o[6] ? 8'hFF : map_mem[addr_o[5:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input kind_e k, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // SPI host: sends frame[nbits-1:0] MSB first, reports the last n_miso bytes seen on MISO.
  task automatic spi_frame(input logic [23:0] frame, input int nbits, input int n_miso,
                           input bit early_csn, input bit hold_csn);
    logic [23:0] rx;
    rx = '0;
    @(negedge clk);
    // NOTE: inputs are driven with blocking assignments away from the clk edge so the
    // DUT never sees a race between stimulus and its own sampling.
    csn_i = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi_i = frame[nbits-1-i];
      #(HALF);
      rx    = {rx[22:0], miso_o};
      sck_i = 1'b1;
      if (early_csn && i == nbits - 1) begin
        @(posedge clk);
        #1 csn_i = 1'b1;
      end
      #(HALF);
      sck_i = 1'b0;
    end
    if (!hold_csn) begin
      #(HALF);
      csn_i = 1'b1;
      #(4 * HALF);
    end
    for (int k = n_miso - 1; k >= 0; k--) obs_miso.push_back(rx[k*8 +: 8]);
  endtask

  // Strobe / error monitor: pops one expectation per strobe or error pulse.
  logic       prev_wen = 1'b0, prev_ren = 1'b0, prev_err = 1'b0;
  int         wen_len = 0, ren_len = 0;
  logic [6:0] wr_addr0, rd_addr0;
  logic [7:0] wr_data0;
  logic       wr_hold_bad, rd_hold_bad;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst_i) begin
      prev_wen = 1'b0;
      prev_ren = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (write_en_o && !prev_wen) begin
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("wr_kind", mon_e.kind, K_WR);
          check("wr_addr", addr_o, mon_e.addr);
          check("wr_data", write_data_o, mon_e.data);
        end
        wr_addr0 = addr_o; wr_data0 = write_data_o; wen_len = 0; wr_hold_bad = 1'b0;
      end
      if (write_en_o) begin
        wen_len++;
        if (addr_o !== wr_addr0 || write_data_o !== wr_data0 || !busy_o) wr_hold_bad = 1'b1;
      end else if (prev_wen) begin
        check("wr_len", wen_len, STROBE);
        check("wr_hold", wr_hold_bad, 0);
      end

      if (read_en_o && !prev_ren) begin
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("rd_kind", mon_e.kind, K_RD);
          check("rd_addr", addr_o, mon_e.addr);
        end
        rd_addr0 = addr_o; ren_len = 0; rd_hold_bad = 1'b0;
      end
      if (read_en_o) begin
        ren_len++;
        if (addr_o !== rd_addr0 || !busy_o) rd_hold_bad = 1'b1;
      end else if (prev_ren) begin
        check("rd_len", ren_len, STROBE);
        check("rd_hold", rd_hold_bad, 0);
      end

      if (frame_err_o) begin
        check("err_width", prev_err, 0);
        if (!prev_err) begin
          if (exp_q.size() == 0) check("err_unexpected", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            check("err_kind", mon_e.kind, K_ERR);
          end
        end
      end

      prev_wen = write_en_o;
      prev_ren = read_en_o;
      prev_err = frame_err_o;
    end
  end

  // MISO monitor: compares each byte the host captured against the queued expectation.
  logic [7:0] miso_got, miso_want;
  always @(negedge clk) begin
    if (obs_miso.size() > 0) begin
      miso_got = obs_miso.pop_front();
      if (exp_miso.size() == 0) check("miso_unexpected", 1, 0);
      else begin
        miso_want = exp_miso.pop_front();
        check("miso_byte", miso_got, miso_want);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i  = 1'b1;
    sck_i  = 1'b0;
    csn_i  = 1'b1;
    mosi_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_addr", addr_o, 0);
    check("rst_wdata", write_data_o, 0);
    check("rst_ctrl", {miso_o, miso_oe_o, write_en_o, read_en_o, busy_o, frame_err_o}, 0);

    // Plain write, then read it back through the map.
    push_exp(K_WR, 7'h05, 8'hA5);
    spi_frame(24'h0005A5, 16, 0, 0, 0);
    push_exp(K_RD, 7'h05, 8'h00); exp_miso.push_back(8'hA5);
    spi_frame(24'h008500, 16, 1, 0, 0);

    // Read returning 0x3C, shifted out MSB first.
    push_exp(K_WR, 7'h05, 8'h3C);
    spi_frame(24'h00053C, 16, 0, 0, 0);
    push_exp(K_RD, 7'h05, 8'h00); exp_miso.push_back(8'h3C);
    spi_frame(24'h008500, 16, 1, 0, 0);

    // Unmapped address forwarded unchanged; map answers 0xFF.
    push_exp(K_RD, 7'h40, 8'h00); exp_miso.push_back(8'hFF);
    spi_frame(24'h00C000, 16, 1, 0, 0);

    // Deselect after 4 command bits: one error pulse, no strobe; next frame decodes.
    push_exp(K_ERR, 7'h00, 8'h00);
    spi_frame(24'h000008, 4, 0, 0, 0);
    push_exp(K_WR, 7'h0A, 8'h5C);
    spi_frame(24'h000A5C, 16, 0, 0, 0);

    // Deselect while the write strobe is running: strobe completes, no error.
    push_exp(K_WR, 7'h06, 8'h3C);
    spi_frame(24'h00063C, 16, 0, 1, 0);

    // Reset in the middle of a data byte.
    spi_frame(24'h00033A, 12, 0, 0, 1);
    @(negedge clk);
    check("mid_addr", addr_o, 7'h33);
    check("mid_oe", miso_oe_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_addr", addr_o, 0);
    check("rst_mid_wdata", write_data_o, 0);
    check("rst_mid_ctrl", {miso_o, miso_oe_o, write_en_o, read_en_o, busy_o, frame_err_o}, 0);
    csn_i = 1'b1;
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    push_exp(K_WR, 7'h01, 8'h11);
    spi_frame(24'h000111, 16, 0, 0, 0);
    push_exp(K_RD, 7'h01, 8'h00); exp_miso.push_back(8'h11);
    spi_frame(24'h008100, 16, 1, 0, 0);

`ifdef SPI_BURST_EN
    // Burst write with address wrap 0x7F -> 0x00.
    push_exp(K_WR, 7'h7F, 8'h11);
    push_exp(K_WR, 7'h00, 8'h22);
    spi_frame(24'h7F1122, 24, 0, 0, 0);
    // Burst read from 0x7F: prefetches 0x00 and then 0x01 after the last byte.
    push_exp(K_RD, 7'h7F, 8'h00);
    push_exp(K_RD, 7'h00, 8'h00);
    push_exp(K_RD, 7'h01, 8'h00);
    exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'h22);
    spi_frame(24'hFF0000, 24, 2, 0, 0);
`else
    // Single-byte frames: the extra byte is ignored and MISO stays 0.
    push_exp(K_WR, 7'h7F, 8'h11);
    spi_frame(24'h7F1122, 24, 0, 0, 0);
    push_exp(K_RD, 7'h01, 8'h00);
    exp_miso.push_back(8'h11);
    exp_miso.push_back(8'h00);
    spi_frame(24'h810000, 24, 2, 0, 0);
`endif

    repeat (40) @(negedge clk);
    check("sb_pending", exp_q.size(), 0);
    check("miso_pending", exp_miso.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
